// File: rtl/rbot_pkg.sv
// Shared types for the cube-robot move sequencer: FSM encoding and the queued command record.
// Pure declarations; no logic.
package rbot_pkg;

  localparam int MOTOR_W = 3;
  localparam int STEPS_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_ACK,
    ST_RUN,
    ST_SETTLE,
    ST_HALT
  } state_e;

  typedef struct packed {
    logic [MOTOR_W-1:0] motor;
    logic               dir;
    logic [STEPS_W-1:0] steps;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  // One-hot select over the full 3-bit index space; callers truncate to NUM_MOTORS.
  function automatic logic [7:0] motor_mask(input logic [MOTOR_W-1:0] m);
    return 8'(1) << m;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Generic synchronous FIFO with first-word-fall-through read; full/empty from extra-bit pointers.
// Zero-latency read of the head entry; pushes while full and pops while empty are ignored.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o)  wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_i  && !empty_o) rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/move_sequencer.sv
// Queues stepper move commands, issues each as a one-cycle start pulse, then tracks the driver's done handshake.
// Push-to-start is two cycles from an empty idle queue; cmd_ready drops when the queue is full or the sequencer has halted.
module move_sequencer
  import rbot_pkg::*;
#(
  parameter int NUM_MOTORS       = 6,
  parameter int FIFO_DEPTH       = 4,
  parameter int STEP_HALF_PERIOD = 50000,
  parameter int SETTLE_CYCLES    = 1000,
  parameter int ACK_TIMEOUT      = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [MOTOR_W-1:0]    cmd_motor,
  input  logic                  cmd_dir,
  input  logic [STEPS_W-1:0]    cmd_steps,
  output logic                  step_clock,
  output logic [NUM_MOTORS-1:0] start,
  output logic [STEPS_W-1:0]    steps,
  output logic [NUM_MOTORS-1:0] dir,
  input  logic [NUM_MOTORS-1:0] done,
  output logic                  busy,
  output logic                  fault,
  output logic [7:0]            moves_done
);

  localparam int CMAX = (SETTLE_CYCLES > ACK_TIMEOUT) ? SETTLE_CYCLES : ACK_TIMEOUT;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] ACK_LAST    = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam int DW = (STEP_HALF_PERIOD > 1) ? $clog2(STEP_HALF_PERIOD) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(STEP_HALF_PERIOD - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);
  localparam logic [MOTOR_W:0] NUM_M = (MOTOR_W + 1)'(NUM_MOTORS);

  state_e                  state_q, state_d;
  logic [MOTOR_W-1:0]      motor_q, motor_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [NUM_MOTORS-1:0]   start_q, start_d;
  logic [STEPS_W-1:0]      steps_q, steps_d;
  logic [NUM_MOTORS-1:0]   dir_q, dir_d;
  logic                    fault_q, fault_d;
  logic [7:0]              moves_q, moves_d;
  logic [DW-1:0]           div_q;
  logic                    step_clk_q;

  cmd_t                    fifo_wdata, fifo_rdata;
  logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [NUM_MOTORS-1:0]   new_mask, cur_mask;
  logic                    done_sel;

  assign cmd_ready  = !fifo_full && (state_q != ST_HALT);
  assign fifo_push  = cmd_valid && cmd_ready;
  assign fifo_wdata = '{motor: cmd_motor, dir: cmd_dir, steps: cmd_steps};

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign new_mask = NUM_MOTORS'(motor_mask(fifo_rdata.motor));
  assign cur_mask = NUM_MOTORS'(motor_mask(motor_q));
  // Masking first keeps stale or X levels on unselected drivers out of the decision.
  assign done_sel = |(done & cur_mask);

  always_comb begin
    state_d  = state_q;
    motor_d  = motor_q;
    cnt_d    = cnt_q;
    start_d  = '0;
    steps_d  = steps_q;
    dir_d    = dir_q;
    fault_d  = fault_q;
    moves_d  = moves_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if ({1'b0, fifo_rdata.motor} < NUM_M) begin
            motor_d = fifo_rdata.motor;
            start_d = new_mask;
            steps_d = fifo_rdata.steps;
            dir_d   = (dir_q & ~new_mask) | (new_mask & {NUM_MOTORS{fifo_rdata.dir}});
            state_d = ST_ISSUE;
          end else begin
            fault_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_ACK;
      end
      ST_ACK: begin
        if (done_sel == 1'b0) begin
          state_d = ST_RUN;
        end else if (cnt_q == ACK_LAST) begin
          fault_d = 1'b1;
          state_d = ST_HALT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RUN: begin
        if (done_sel == 1'b1) begin
          moves_d = moves_q + 8'd1;
          cnt_d   = '0;
          state_d = (SETTLE_CYCLES == 0) ? ST_IDLE : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) state_d = ST_IDLE;
        else                      cnt_d   = cnt_q + CNT_ONE;
      end
      ST_HALT: ;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      motor_q <= '0;
      cnt_q   <= '0;
      start_q <= '0;
      steps_q <= '0;
      dir_q   <= '0;
      fault_q <= 1'b0;
      moves_q <= '0;
    end else begin
      state_q <= state_d;
      motor_q <= motor_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      steps_q <= steps_d;
      dir_q   <= dir_d;
      fault_q <= fault_d;
      moves_q <= moves_d;
    end
  end

  // Free-running divider shared by every driver; deliberately ignores FSM state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_q      <= '0;
      step_clk_q <= 1'b0;
    end else if (div_q == DIV_LAST) begin
      div_q      <= '0;
      step_clk_q <= ~step_clk_q;
    end else begin
      div_q <= div_q + DIV_ONE;
    end
  end

  assign step_clock = step_clk_q;
  assign start      = start_q;
  assign steps      = steps_q;
  assign dir        = dir_q;
  assign fault      = fault_q;
  assign moves_done = moves_q;
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;

endmodule
